// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads with extension, read-modify-write byte/half stores.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete at once with resp_err.
//
// state   | meaning
// S_IDLE  | ready for a request
// S_READ  | memory read in flight, RD_LAT cycles
// S_WRITE | single-cycle memory write
// S_RESP  | one-cycle response pulse
module load_store_unit #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_lat_cnt;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
    // Sub-word stores overlay the new lane(s) onto the word just read.
    w_merge = mem_rdata;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'd0:    w_merge[7:0]   = r_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end else if (r_size == 2'b01) begin
      if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
      else           w_merge[15:0]  = r_wdata[15:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misalign)                w_next = S_RESP;
          else if (req_we && req_size[1]) w_next = S_WRITE;
          else                           w_next = S_READ;
        end
      end
      S_READ:  if (r_lat_cnt == 2'd0) w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_lat_cnt    <= 2'd0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_lat_cnt <= LAT_INIT;
            if (w_misalign) begin
              r_resp_rdata <= 32'd0;
              r_resp_err   <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (r_lat_cnt != 2'd0) begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end else if (r_we) begin
            r_wdata <= w_merge;
          end else begin
            r_resp_rdata <= w_load;
            r_resp_err   <= 1'b0;
          end
        end
        S_WRITE: begin
          r_resp_rdata <= 32'd0;
          r_resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_en     = (r_state == S_READ) || (r_state == S_WRITE);
  assign mem_wr_en  = (r_state == S_WRITE);
  assign mem_addr   = mem_en ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata  = mem_wr_en ? r_wdata : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: lane/extension model plus per-cycle protocol compare.
module tb_load_store_unit;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_en(mem_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Bench memory: combinational read, written on mem_wr_en or preload.
  logic [31:0] tb_mem [0:15];
  logic        ld_en;
  logic [31:0] ld_val;
  int          cyc = 0;
  assign mem_rdata = tb_mem[mem_addr[5:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en)          tb_mem[4] <= ld_val;
    else if (mem_wr_en) tb_mem[mem_addr[5:2]] <= mem_wdata;
  end

  int n_pass = 0, n_total = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model state: reference memory and the expectations for the current request.
  logic [31:0] ref_mem [0:15];
  bit          chk_en = 1'b0;
  int          exp_c = -100, exp_l = 1;
  bit          exp_we = 1'b0, exp_err = 1'b0, prev_err = 1'b0;
  logic [31:0] exp_rdata = 0, prev_rdata = 0, exp_wdata = 0, exp_addr = 0;

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !(cyc > exp_c && cyc <= exp_c + exp_l)});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, cyc == exp_c + exp_l});
      chk("mem_en", {31'd0, mem_en}, {31'd0, cyc > exp_c && cyc < exp_c + exp_l});
      chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, exp_we && cyc == exp_c + exp_l - 1});
      chk("mem_addr", mem_addr, mem_en ? (exp_addr & 32'hFFFF_FFFC) : 32'd0);
      chk("mem_wdata", mem_wdata, mem_wr_en ? exp_wdata : 32'd0);
      if (cyc >= exp_c + exp_l) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      end else begin
        chk("resp_rdata_hold", resp_rdata, prev_rdata);
        chk("resp_err_hold", {31'd0, resp_err}, {31'd0, prev_err});
      end
    end
  end

  // Issue one request at the current negedge and compute what it must do.
  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int idx, nbytes, off;
    bit mis;
    logic [31:0] word, mask, v, nw;
    idx    = int'(addr[5:2]);
    word   = ref_mem[idx];
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off    = (nbytes == 1) ? int'(addr % 4) : (nbytes == 2) ? int'((addr % 4) / 2) * 2 : 0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (nbytes == 2 && addr % 2 != 0) || (nbytes == 4 && addr % 4 != 0);
`else
    mis = 1'b0;
`endif
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    v = (word >> (8 * off)) & mask;
    if (sgn && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    nw = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
    prev_rdata = exp_rdata;
    prev_err   = exp_err;
    exp_err    = mis;
    exp_we     = we && !mis;
    exp_rdata  = (mis || we) ? 32'd0 : v;
    exp_wdata  = nw;
    exp_addr   = addr;
    exp_l      = mis ? 1 : !we ? RD_LAT + 1 : (nbytes == 4) ? 2 : RD_LAT + 2;
    if (exp_we) ref_mem[idx] = nw;
    exp_c      = cyc;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = 32'hDEAD_BEEF;
    repeat (exp_l + 1) @(negedge clk);
    chk("mem_word", tb_mem[idx], ref_mem[idx]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    ld_en = 1'b1; ld_val = 32'h8899_AABB;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    ref_mem[4] = 32'h8899_AABB;
    repeat (3) @(negedge clk);
    ld_en = 1'b0;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lit_ldw_mis_err", {31'd0, resp_err}, 32'd1);
    chk("lit_ldw_mis_data", resp_rdata, 32'd0);
`else
    chk("lit_ldw_noalign", resp_rdata, 32'h8899_AABB);
`endif
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'd0);
    chk("lit_ldb_s", resp_rdata, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    chk("lit_ldh_u", resp_rdata, 32'h0000_8899);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0055);
    chk("lit_stb_mem", tb_mem[4], 32'h5599_AABB);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    chk("lit_ldw", resp_rdata, 32'h5599_AABB);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
    chk("lit_stw_mem", tb_mem[4], 32'h1234_5678);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'd0);
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'd0);
    chk("lit_ldb_pos", resp_rdata, 32'h0000_0034);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
    chk("lit_ldh_s", resp_rdata, 32'hFFFF_ABCD);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_EEEE);
    do_req(1'b1, 2'b00, 1'b0, 32'h24, 32'h0000_0077);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);

    // Reset while a half store is in its read phase.
    chk_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_1111;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_read", {31'd0, mem_en & ~mem_wr_en}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_wr", {31'd0, mem_wr_en}, 32'd0);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    chk("abort_mem", tb_mem[4], ref_mem[4]);
    exp_c = -100; exp_l = 1; exp_we = 1'b0;
    exp_rdata = 32'd0; exp_err = 1'b0;
    chk_en = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (legal 1..3).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  request present.
REQ-005 SHALL have port req_ready  out  1  unit can accept; transfer when req_valid and req_ready are both 1.
REQ-006 SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port req_signed  in  1  load sign-extend (1) or zero-extend (0); ignored for stores.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-012 SHALL have port resp_rdata  out  32  extended load data; 0 for stores.
REQ-013 SHALL have port resp_err  out  1  misaligned-access flag, valid with resp_valid.
REQ-014 SHALL have ports mem_en out 1, mem_wr_en out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, driving the word-wide data memory.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL latch we/size/signed/addr/wdata on acceptance (cycle T).
REQ-017 SHALL drive mem_addr = {addr[31:2],2'b00} and mem_en = 1 in READ and WRITE; mem_en = 0, mem_wr_en = 0 in IDLE and RESP.
REQ-018 SHALL use little-endian lanes: byte n at bits [8n+7:8n], half at addr[1].
REQ-019 Load: IDLE -> READ for exactly RD_LAT cycles; mem_rdata sampled at edge ending last READ cycle -> RESP; resp_valid at T+RD_LAT+1.
REQ-020 Word store: IDLE -> WRITE (one cycle, mem_wr_en = 1, mem_wdata = wdata) -> RESP; resp_valid at T+2; no READ cycle.
REQ-021 Byte/half store: IDLE -> READ (RD_LAT cycles) -> WRITE with mem_wdata = read word, target lane(s) replaced by wdata low bits -> RESP; resp_valid at T+RD_LAT+2.
REQ-022 mem_wr_en SHALL be 1 only in WRITE, exactly one cycle per store.
REQ-023 RESP -> IDLE unconditionally; max one request per RESP.
REQ-024 resp_rdata, resp_err SHALL hold last response values until next RESP.

Reset
REQ-025 rst_n = 0 at an edge SHALL force IDLE; req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_en = 0, mem_wr_en = 0, mem_addr = 0, mem_wdata = 0.
REQ-026 Reset during READ or WRITE SHALL abandon the operation; no write and no resp_valid for it after the reset edge.

Configuration
REQ-027 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0] = 1 or word with addr[1:0] != 0 SHALL go IDLE -> RESP directly, resp_err = 1, resp_rdata = 0, no mem_en; resp_valid at T+1.
REQ-028 Macro undefined: resp_err tied 0; half ignores addr[0], word ignores addr[1:0]; access proceeds normally.

Verification (RD_LAT = 1, word 0x10 preloaded 0x8899AABB)
REQ-029 Load byte signed addr 0x11 -> resp_valid at T+2, resp_rdata 0xFFFFFFAA, mem_wr_en never 1.
REQ-030 Load half unsigned addr 0x12 -> resp_rdata 0x00008899.
REQ-031 Store byte addr 0x13 wdata 0x00000055 -> one READ, one WRITE cycle mem_wdata 0x5599AABB, resp_valid at T+3; following load word 0x10 -> 0x5599AABB.
REQ-032 Store word addr 0x10 wdata 0x12345678 -> mem_wr_en at T+1 only, no read cycle, resp_valid at T+2.
REQ-033 Load word addr 0x12: macro defined -> resp_err 1 at T+1, mem_en never 1; undefined -> resp_rdata 0x8899AABB, resp_err 0.
REQ-034 Store half addr 0x10, rst_n = 0 during READ -> no mem_wr_en, no resp_valid, req_ready = 1 after reset edge, memory unchanged.
